country_request_scheduler: RTL and testbench
============================================

# country_request_scheduler

Request scheduler in front of the highway/country traffic-light sequencer. Turns raw country-side car detection, emergency-vehicle detection and time of day into a single service request for the light controller. Enforces the country-side wait time, the night lockout and a highway hold-off between services. Emergency requests bypass all three. It is the only block that starts a country-side cycle; the light sequencer only answers its handshake.

## Interface
Parameters:
- CLK_PER_SEC, 50000000, clock cycles per second (prescaler terminal count + 1)
- WAIT_SEC, 180, seconds a normal country request waits before issue
- HOLDOFF_SEC, 60, minimum highway-green seconds after any completed service
- ACK_TIMEOUT_SEC, 10, seconds allowed between svc_req rise and svc_ack
- NIGHT_START_HR, 21, first hour of night lockout
- NIGHT_END_HR, 5, first hour after night lockout

Ports:
- clock  in  1  single system clock, rising edge
- clear  in  1  reset, asynchronous, active-high
- car_det  in  1  country-side vehicle present, synchronous level
- emerg_det  in  1  ambulance/fire/police present, synchronous level
- hours  in  5  current hour, 0–23
- svc_ack  in  1  one-cycle pulse: controller accepted request
- svc_done  in  1  one-cycle pulse: controller finished country cycle
- svc_req  out  1  service request, level, held until acked
- svc_emerg  out  1  request is emergency; valid while svc_req=1
- pending  out  1  normal request latched, waiting
- night  out  1  registered night-window flag
- fault  out  1  sticky ack-timeout flag

## Operation
- All outputs are registered. Reset value of every output is 0. State resets to IDLE.
- night = 1 when hours ≥ NIGHT_START_HR or hours < NIGHT_END_HR. Values 24–31 count as day.
  - The flag is registered, so it lags hours by 1 cycle.
- Second timer: a prescaler and a seconds counter, both zeroed on every state entry.
  - A duration of N seconds is therefore exactly N*CLK_PER_SEC cycles from entry.
- States:
  - IDLE: emerg_det → ISSUE with svc_emerg=1. Else car_det && !night → WAIT with pending=1.
  - WAIT: the request stays latched even if car_det drops.
    - emerg_det → ISSUE (emerg), pending=0.
    - night rising → IDLE, pending=0.
    - WAIT_SEC elapsed → ISSUE (normal), pending=0.
  - ISSUE: svc_req=1.
    - emerg_det before ack upgrades svc_emerg to 1. svc_emerg never downgrades.
    - svc_ack → SERVE.
    - ACK_TIMEOUT_SEC elapsed without ack → fault=1, IDLE.
  - SERVE: svc_req=0. emerg_det is ignored. svc_done → HOLDOFF.
  - HOLDOFF: car_det is ignored and not latched.
    - emerg_det → ISSUE (emerg).
    - HOLDOFF_SEC elapsed → IDLE.
- svc_ack and svc_done in the same ISSUE cycle: treat as ack then done and go directly to HOLDOFF.
- svc_ack or svc_done outside ISSUE/SERVE: ignored.
- emerg_det and car_det together: emergency wins.
- clear mid-operation: immediate return to IDLE. All outputs go to 0, including fault. Timers are zeroed.

## Timing
- emerg_det sampled high at edge n in IDLE/WAIT/HOLDOFF → svc_req=svc_emerg=1 after edge n.
- car_det sampled at edge n in IDLE (day) → pending=1 after edge n.
  - svc_req=1 after edge n+WAIT_SEC*CLK_PER_SEC.
- svc_ack sampled at edge m → svc_req=0 after edge m.
- svc_done sampled at edge k → HOLDOFF.
  - IDLE reached after edge k+HOLDOFF_SEC*CLK_PER_SEC.
- ACK timeout: fault=1 and svc_req=0 after edge ACK_TIMEOUT_SEC*CLK_PER_SEC counted from ISSUE entry.

## Configuration
- SCHED_NIGHT_LOCK_EN defined: night lockout active exactly as described above.
- SCHED_NIGHT_LOCK_EN undefined:
  - night is tied to 0 and hours is unused.
  - Normal requests are served at any hour.
  - The hour-compare logic is not synthesized.

## Test plan
Bench parameters: CLK_PER_SEC=4, WAIT_SEC=3, HOLDOFF_SEC=2, ACK_TIMEOUT_SEC=2; hours=12 unless stated.
1. Assert clear mid-WAIT → all outputs 0 next cycle. After release, car_det restarts a full 12-cycle wait.
2. One-cycle car_det pulse → pending=1 next cycle. svc_req=1, svc_emerg=0 exactly 12 cycles later. Ack → svc_req=0 next cycle.
3. hours=22 (macro on), car_det held 40 cycles → svc_req stays 0, night=1. Then emerg_det → svc_req=1, svc_emerg=1 next cycle.
4. emerg_det 5 cycles into WAIT → ISSUE with svc_emerg=1 next cycle, pending=0. Separately, emerg_det during normal ISSUE before ack → svc_emerg goes 0→1, svc_req stays 1.
5. No svc_ack for 8 cycles after svc_req → fault=1, svc_req=0. fault stays 1 through later services until clear.
6. svc_ack+svc_done in the same cycle → HOLDOFF. car_det during the 8 holdoff cycles is ignored (pending=0). emerg_det during holdoff → svc_req next cycle.

Source files
------------

// File: rtl/country_request_scheduler.sv
// Country-side service request scheduler: wait timer, night lockout, highway hold-off, emergency bypass.
// Optional night lockout is compiled in with `define SCHED_NIGHT_LOCK_EN.
module country_request_scheduler #(
  parameter int CLK_PER_SEC     = 50000000,
  parameter int WAIT_SEC        = 180,
  parameter int HOLDOFF_SEC     = 60,
  parameter int ACK_TIMEOUT_SEC = 10,
  parameter int NIGHT_START_HR  = 21,
  parameter int NIGHT_END_HR    = 5
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       car_det,
  input  logic       emerg_det,
  input  logic [4:0] hours,
  input  logic       svc_ack,
  input  logic       svc_done,
  output logic       svc_req,
  output logic       svc_emerg,
  output logic       pending,
  output logic       night,
  output logic       fault
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WAIT    = 3'd1;
  localparam logic [2:0] ISSUE   = 3'd2;
  localparam logic [2:0] SERVE   = 3'd3;
  localparam logic [2:0] HOLDOFF = 3'd4;

  localparam int PW      = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam int SEC_MAX = (WAIT_SEC > HOLDOFF_SEC)
                         ? ((WAIT_SEC > ACK_TIMEOUT_SEC) ? WAIT_SEC : ACK_TIMEOUT_SEC)
                         : ((HOLDOFF_SEC > ACK_TIMEOUT_SEC) ? HOLDOFF_SEC : ACK_TIMEOUT_SEC);
  localparam int SW      = $clog2(SEC_MAX + 1);

  logic [2:0]    state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [SW-1:0] sec_q, sec_d;
  logic          svc_req_q, svc_emerg_q, svc_emerg_d;
  logic          pending_q, fault_q, fault_d;
  logic          night_q, night_d;
  logic          sec_tick, timed;
  logic          wait_exp, hold_exp, ack_exp;

`ifdef SCHED_NIGHT_LOCK_EN
  // Hours 24..31 are out of range and treated as day.
  always_comb begin
    night_d = ((hours >= 5'(NIGHT_START_HR)) && (hours <= 5'd23)) ||
              (hours < 5'(NIGHT_END_HR));
  end
`else
  logic unused_hours;
  assign unused_hours = ^hours;
  always_comb night_d = 1'b0;
`endif

  // A duration of N seconds expires on the N*CLK_PER_SEC-th edge after entry.
  assign sec_tick = (presc_q == PW'(CLK_PER_SEC - 1));
  assign wait_exp = sec_tick && (sec_q == SW'(WAIT_SEC - 1));
  assign hold_exp = sec_tick && (sec_q == SW'(HOLDOFF_SEC - 1));
  assign ack_exp  = sec_tick && (sec_q == SW'(ACK_TIMEOUT_SEC - 1));
  assign timed    = (state_q == WAIT) || (state_q == ISSUE) || (state_q == HOLDOFF);

  always_comb begin
    state_d     = state_q;
    svc_emerg_d = svc_emerg_q;
    fault_d     = fault_q;
    case (state_q)
      IDLE: begin
        if (emerg_det) begin
          state_d     = ISSUE;
          svc_emerg_d = 1'b1;
        end else if (car_det && !night_q) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (emerg_det) begin
          state_d     = ISSUE;
          svc_emerg_d = 1'b1;
        end else if (night_q) begin
          state_d = IDLE;
        end else if (wait_exp) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (emerg_det) svc_emerg_d = 1'b1;
        if (svc_ack) begin
          state_d = svc_done ? HOLDOFF : SERVE;
        end else if (ack_exp) begin
          state_d = IDLE;
          fault_d = 1'b1;
        end
      end
      SERVE: begin
        if (svc_done) state_d = HOLDOFF;
      end
      HOLDOFF: begin
        if (emerg_det) begin
          state_d     = ISSUE;
          svc_emerg_d = 1'b1;
        end else if (hold_exp) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // svc_emerg only has meaning alongside svc_req.
    if (state_d != ISSUE) svc_emerg_d = 1'b0;
  end

  always_comb begin
    presc_d = presc_q;
    sec_d   = sec_q;
    if (state_d != state_q) begin
      presc_d = '0;
      sec_d   = '0;
    end else if (timed) begin
      if (sec_tick) begin
        presc_d = '0;
        sec_d   = sec_q + 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q     <= IDLE;
      presc_q     <= '0;
      sec_q       <= '0;
      svc_req_q   <= 1'b0;
      svc_emerg_q <= 1'b0;
      pending_q   <= 1'b0;
      fault_q     <= 1'b0;
      night_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      sec_q       <= sec_d;
      svc_req_q   <= (state_d == ISSUE);
      svc_emerg_q <= svc_emerg_d;
      pending_q   <= (state_d == WAIT);
      fault_q     <= fault_d;
      night_q     <= night_d;
    end
  end

  assign svc_req   = svc_req_q;
  assign svc_emerg = svc_emerg_q;
  assign pending   = pending_q;
  assign night     = night_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_country_request_scheduler.sv
// Directed bench for country_request_scheduler; expectations queued per step and checked on output.
module tb_country_request_scheduler;

  logic       clock, clear, car_det, emerg_det, svc_ack, svc_done;
  logic [4:0] hours;
  logic       svc_req, svc_emerg, pending, night, fault;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [4:0] v;   // {svc_req, svc_emerg, pending, night, fault}
  } exp_t;
  exp_t sb[$];

  country_request_scheduler #(
    .CLK_PER_SEC(4), .WAIT_SEC(3), .HOLDOFF_SEC(2), .ACK_TIMEOUT_SEC(2),
    .NIGHT_START_HR(21), .NIGHT_END_HR(5)
  ) dut (
    .clock(clock), .clear(clear), .car_det(car_det), .emerg_det(emerg_det),
    .hours(hours), .svc_ack(svc_ack), .svc_done(svc_done),
    .svc_req(svc_req), .svc_emerg(svc_emerg), .pending(pending),
    .night(night), .fault(fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

`ifdef SCHED_NIGHT_LOCK_EN
  localparam logic NT = 1'b1;
`else
  localparam logic NT = 1'b0;
`endif

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Queue the expected outputs, advance n edges, then compare against the DUT.
  task automatic step(input string tag, input int n, input logic [4:0] v);
    exp_t e, got;
    logic [4:0] obs;
    e.tag = tag;
    e.v   = v;
    sb.push_back(e);
    tick(n);
    got = sb.pop_front();
    obs = {svc_req, svc_emerg, pending, night, fault};
    checks++;
    assert (obs === got.v) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", got.tag, obs, got.v);
    end
  endtask

  // Acknowledge, complete, and sit out the 8-cycle hold-off.
  task automatic finish_service(input logic flt);
    svc_ack = 1'b1;
    tick(1);
    svc_ack  = 1'b0;
    svc_done = 1'b1;
    tick(1);
    svc_done = 1'b0;
    tick(8);
    if (flt) begin end
  endtask

  initial begin
    clear = 1'b1; car_det = 1'b0; emerg_det = 1'b0;
    svc_ack = 1'b0; svc_done = 1'b0; hours = 5'd12;
    step("reset", 2, 5'b00000);
    clear = 1'b0;
    tick(1);

    // Clear in the middle of a wait, then a full fresh wait.
    car_det = 1'b1;
    step("t1_pend", 1, 5'b00100);
    car_det = 1'b0;
    tick(4);
    clear = 1'b1;
    step("t1_clear", 1, 5'b00000);
    clear = 1'b0;
    tick(1);
    car_det = 1'b1;
    step("t1_pend2", 1, 5'b00100);
    car_det = 1'b0;
    step("t1_wait11", 11, 5'b00100);
    step("t1_issue", 1, 5'b10000);
    finish_service(1'b0);

    // Single-cycle car pulse, normal issue after exactly 12 cycles, ack drops req.
    car_det = 1'b1;
    step("t2_pend", 1, 5'b00100);
    car_det = 1'b0;
    step("t2_wait11", 11, 5'b00100);
    step("t2_issue", 1, 5'b10000);
    svc_ack = 1'b1;
    step("t2_ack", 1, 5'b00000);
    svc_ack  = 1'b0;
    svc_done = 1'b1;
    step("t2_done", 1, 5'b00000);
    svc_done = 1'b0;
    tick(8);

    // Emergency five cycles into a wait.
    car_det = 1'b1;
    step("t4_pend", 1, 5'b00100);
    car_det = 1'b0;
    tick(5);
    emerg_det = 1'b1;
    step("t4_emerg_wait", 1, 5'b11000);
    emerg_det = 1'b0;
    finish_service(1'b0);

    // Emergency upgrades a normal request, no downgrade after it drops.
    car_det = 1'b1;
    tick(1);
    car_det = 1'b0;
    step("t4_issue", 12, 5'b10000);
    emerg_det = 1'b1;
    step("t4_upgrade", 1, 5'b11000);
    emerg_det = 1'b0;
    step("t4_no_downgrade", 1, 5'b11000);
    finish_service(1'b0);

    // Ack and done together go straight to hold-off; car ignored there.
    car_det = 1'b1;
    tick(1);
    car_det = 1'b0;
    step("t6_issue", 12, 5'b10000);
    svc_ack = 1'b1; svc_done = 1'b1;
    step("t6_ackdone", 1, 5'b00000);
    svc_ack = 1'b0; svc_done = 1'b0;
    car_det = 1'b1;
    step("t6_hold_car", 4, 5'b00000);
    emerg_det = 1'b1;
    step("t6_emerg_hold", 1, 5'b11000);
    emerg_det = 1'b0; car_det = 1'b0;
    svc_ack = 1'b1;
    tick(1);
    svc_ack  = 1'b0;
    svc_done = 1'b1;
    tick(1);
    svc_done = 1'b0;
    car_det  = 1'b1;
    step("t6_hold_end", 8, 5'b00000);
    step("t6_idle_car", 1, 5'b00100);
    car_det = 1'b0;
    step("t5_issue", 12, 5'b10000);

    // Ack timeout: fault after 8 cycles, sticky through another service.
    step("t5_pre", 7, 5'b10000);
    step("t5_fault", 1, 5'b00001);
    emerg_det = 1'b1;
    step("t5_emerg_fault", 1, 5'b11001);
    emerg_det = 1'b0;
    svc_ack = 1'b1;
    step("t5_ack_fault", 1, 5'b00001);
    svc_ack  = 1'b0;
    svc_done = 1'b1;
    step("t5_done_fault", 1, 5'b00001);
    svc_done = 1'b0;
    step("t5_hold_fault", 8, 5'b00001);
    clear = 1'b1;
    step("t5_clear", 1, 5'b00000);
    clear = 1'b0;
    tick(1);

    // Night handling.
    hours = 5'd22;
    step("t3_night", 1, {3'b000, NT, 1'b0});
`ifdef SCHED_NIGHT_LOCK_EN
    car_det = 1'b1;
    step("t3_lock", 40, 5'b00010);
    emerg_det = 1'b1;
    step("t3_emerg", 1, 5'b11010);
    emerg_det = 1'b0; car_det = 1'b0;
    finish_service(1'b0);
    hours = 5'd12;
    step("t3_day", 1, 5'b00000);
    car_det = 1'b1;
    step("t3_pend", 1, 5'b00100);
    car_det = 1'b0;
    hours = 5'd3;
    step("t3_night_rise", 1, 5'b00110);
    step("t3_night_drop", 1, 5'b00010);
    hours = 5'd25;
    step("t3_hour25_day", 1, 5'b00000);
`else
    car_det = 1'b1;
    step("t3_anyhour", 1, 5'b00100);
    emerg_det = 1'b1;
    step("t3_emerg", 1, 5'b11000);
    emerg_det = 1'b0; car_det = 1'b0;
    finish_service(1'b0);
`endif
    hours = 5'd12;
    step("final_idle", 2, 5'b00000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
